mux_l1l2_tx: RTL and testbench

- Transmit-side counterpart of the PHY RX demux tree. It takes four parallel byte lanes (lane 0..3) and produces one serial byte stream in the clk_4f domain.
- The four lanes are sampled as a frame once every 4 clk_4f cycles. The bytes are then emitted one per cycle in lane order 0,1,2,3.
- Valid is carried per byte. Invalid slots emit IDLE_BYTE.
- Sits in phy_tx ahead of the serializer. Its output stream matches what the RX demux tree expects on data_000/valid_000.

---
 rtl/phy_tx_pkg.sv | 21 ++
 rtl/tx_slot_counter.sv | 31 +++
 rtl/mux_l1l2_tx.sv | 109 ++++++++++
 tb/tb_mux_l1l2_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// Shared PHY lane numbering, used by both the TX mux and the RX demux tree.
package phy_tx_pkg;

  localparam int LANES  = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] lane_idx_t;

  localparam lane_idx_t L0 = 2'd0;
  localparam lane_idx_t L1 = 2'd1;
  localparam lane_idx_t L2 = 2'd2;
  localparam lane_idx_t L3 = 2'd3;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;

  // Next TDM slot, wrapping after the last lane.
  function automatic lane_idx_t next_slot(input lane_idx_t cur);
    return (cur == L3) ? L0 : lane_idx_t'(cur + 1'b1);
  endfunction

endpackage

// File: rtl/tx_slot_counter.sv
// Free-running TDM slot counter; slot 0 marks the frame capture cycle.
module tx_slot_counter
  import phy_tx_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  output lane_idx_t cnt_o,
  output logic      capture_o
);

  lane_idx_t cnt_q;
  lane_idx_t cnt_d;

  // Advance one slot every cycle, no enable, wrapping back to lane 0.
  always_comb begin
    cnt_d = next_slot(cnt_q);
  end

  // Slot register; reset puts the first edge after release on a capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= L0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign capture_o = (cnt_q == L0);

endmodule

// File: rtl/mux_l1l2_tx.sv
// Four-lane to one-byte TDM serializer for the PHY transmit path.
module mux_l1l2_tx
  import phy_tx_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(IDLE_BYTE_DEF)
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic              valid_2,
  input  logic              valid_3,
  output logic [DATA_W-1:0] data_000,
  output logic              valid_000,
  output logic [1:0]        lane_id,
  output logic              frame_start,
  output logic              capture
);

  lane_idx_t cnt;
  logic      captureNow;

  // Lanes 1..3 are parked here; lane 0 goes straight to the output.
  logic [LANES-1:1][DATA_W-1:0] shData_q;
  logic [LANES-1:1]             shValid_q;

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              valid_q;
  logic              valid_d;
  lane_idx_t         laneId_q;
  logic              frameStart_q;

  tx_slot_counter u_slot_counter (
    .clk_i    (clk_4f),
    .rst_ni   (reset_L),
    .cnt_o    (cnt),
    .capture_o(captureNow)
  );

  // Pick the byte for the current slot and substitute idle for invalid lanes.
  always_comb begin
    valid_d = valid_0;
    data_d  = data_0;
    unique case (cnt)
      L0: begin
        valid_d = valid_0;
        data_d  = data_0;
      end
      L1: begin
        valid_d = shValid_q[1];
        data_d  = shData_q[1];
      end
      L2: begin
        valid_d = shValid_q[2];
        data_d  = shData_q[2];
      end
      L3: begin
        valid_d = shValid_q[3];
        data_d  = shData_q[3];
      end
      default: begin
        valid_d = 1'b0;
        data_d  = IDLE_BYTE;
      end
    endcase
    if (!valid_d) begin
      data_d = IDLE_BYTE;
    end
  end

  // Shadow bank loads on the capture edge and holds for the rest of the frame.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      shData_q  <= '0;
      shValid_q <= '0;
    end else if (captureNow) begin
      shData_q  <= {data_3, data_2, data_1};
      shValid_q <= {valid_3, valid_2, valid_1};
    end
  end

  // Registered serial output with its lane tag and frame marker.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      data_q       <= IDLE_BYTE;
      valid_q      <= 1'b0;
      laneId_q     <= L0;
      frameStart_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      laneId_q     <= cnt;
      frameStart_q <= captureNow;
    end
  end

  assign data_000    = data_q;
  assign valid_000   = valid_q;
  assign lane_id     = laneId_q;
  assign frame_start = frameStart_q;
  assign capture     = captureNow;

endmodule

// File: tb/tb_mux_l1l2_tx.sv
// Scoreboard bench for the 4-lane TX TDM mux.
module tb_mux_l1l2_tx;

  localparam int         W    = 8;
  localparam logic [7:0] IDLE = 8'h00;

  localparam int K_RANDOM  = 0;
  localparam int K_A_PAT   = 1;
  localparam int K_55_ODD  = 2;
  localparam int K_D2_CHG  = 3;
  localparam int K_ALL_INV = 4;
  localparam int K_KEEP    = 5;
  localparam int K_B_PAT   = 6;

  logic         clk;
  logic         reset_L;
  logic [W-1:0] laneData [4];
  logic         laneValid [4];
  logic [W-1:0] data_000;
  logic         valid_000;
  logic [1:0]   lane_id;
  logic         frame_start;
  logic         capture;

  // One expected output slot: {data, valid, lane, frame_start}.
  logic [11:0] expQ [$];

  int errors = 0;
  int checks = 0;
  int slotB  = 0;
  int expCnt = 0;
  bit inReset = 1'b1;
  bit stopMon = 1'b0;

  mux_l1l2_tx dut (
    .clk_4f     (clk),
    .reset_L    (reset_L),
    .data_0     (laneData[0]),
    .data_1     (laneData[1]),
    .data_2     (laneData[2]),
    .data_3     (laneData[3]),
    .valid_0    (laneValid[0]),
    .valid_1    (laneValid[1]),
    .valid_2    (laneValid[2]),
    .valid_3    (laneValid[3]),
    .data_000   (data_000),
    .valid_000  (valid_000),
    .lane_id    (lane_id),
    .frame_start(frame_start),
    .capture    (capture)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: a captured frame is emitted as four slots in lane order.
  task automatic pushFrame();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] d;
      d = laneValid[k] ? laneData[k] : IDLE;
      expQ.push_back({d, laneValid[k], 2'(k), (k == 0)});
    end
  endtask

  // Set lane inputs for this cycle; on the cycle before a capture edge, record the frame.
  task automatic driveInputs(input int kind);
    if (slotB == 0) begin
      for (int k = 0; k < 4; k++) begin
        case (kind)
          K_RANDOM: begin
            laneData[k]  = 8'($urandom_range(0, 255));
            laneValid[k] = 1'($urandom_range(0, 1));
          end
          K_A_PAT: begin
            laneData[k]  = 8'hA0 + 8'(k);
            laneValid[k] = 1'b1;
          end
          K_55_ODD: begin
            laneData[k]  = 8'h55;
            laneValid[k] = (k % 2 == 0);
          end
          K_D2_CHG: begin
            laneData[k]  = (k == 2) ? 8'h11 : 8'h30 + 8'(k);
            laneValid[k] = 1'b1;
          end
          K_ALL_INV: begin
            laneData[k]  = 8'hC0 + 8'(k);
            laneValid[k] = 1'b0;
          end
          K_B_PAT: begin
            laneData[k]  = 8'hB0 + 8'(k);
            laneValid[k] = 1'b1;
          end
          default: begin
          end
        endcase
      end
      pushFrame();
    end else begin
      if (kind == K_RANDOM) begin
        for (int k = 0; k < 4; k++) begin
          laneData[k]  = 8'($urandom_range(0, 255));
          laneValid[k] = 1'($urandom_range(0, 1));
        end
      end else if (kind == K_D2_CHG) begin
        laneData[2] = 8'h22;
      end
    end
    slotB = (slotB + 1) % 4;
  endtask

  task automatic applyStimulus(input int kind);
    @(negedge clk);
    #1;
    driveInputs(kind);
  endtask

  task automatic runFrame(input int kind);
    for (int i = 0; i < 4; i++) applyStimulus(kind);
  endtask

  // Monitor: compares each output slot against the scoreboard, away from the active edge.
  always @(negedge clk) begin
    if (!stopMon) begin
      if (inReset) begin
        expCnt = 0;
        checkOutput("reset_outputs", {20'd0, data_000, valid_000, lane_id, frame_start},
                    {20'd0, IDLE, 1'b0, 2'd0, 1'b0});
        checkOutput("reset_capture", {31'd0, capture}, 32'd1);
      end else begin
        expCnt = (expCnt + 1) % 4;
        checkOutput("capture", {31'd0, capture}, {31'd0, (expCnt == 0)});
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_underflow: output slot with no expected entry at %0t", $time);
        end else begin
          logic [11:0] e;
          e = expQ.pop_front();
          checkOutput("slot", {20'd0, data_000, valid_000, lane_id, frame_start}, {20'd0, e});
        end
      end
    end
  end

  initial begin
    reset_L = 1'b1;
    for (int k = 0; k < 4; k++) begin
      laneData[k]  = '0;
      laneValid[k] = 1'b0;
    end
    #1;
    reset_L = 1'b0;
    repeat (3) @(negedge clk);

    // Release on a negedge; the very next edge is a capture edge.
    #1;
    reset_L = 1'b1;
    inReset = 1'b0;
    slotB   = 0;
    driveInputs(K_A_PAT);
    for (int i = 0; i < 3; i++) applyStimulus(K_A_PAT);
    runFrame(K_A_PAT);
    runFrame(K_A_PAT);

    runFrame(K_55_ODD);
    runFrame(K_55_ODD);

    runFrame(K_D2_CHG);
    runFrame(K_KEEP);

    runFrame(K_ALL_INV);
    runFrame(K_ALL_INV);

    // Async reset while lane 1 of an A-pattern frame is on the output.
    runFrame(K_RANDOM);
    applyStimulus(K_A_PAT);
    applyStimulus(K_A_PAT);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_lane1", {22'd0, data_000, lane_id}, {22'd0, 8'hA1, 2'd1});
    #2;
    reset_L = 1'b0;
    inReset = 1'b1;
    expQ.delete();
    #1;
    checkOutput("async_reset_clear", {20'd0, data_000, valid_000, lane_id, frame_start},
                {20'd0, IDLE, 1'b0, 2'd0, 1'b0});
    repeat (2) @(negedge clk);
    #1;
    reset_L = 1'b1;
    inReset = 1'b0;
    slotB   = 0;
    driveInputs(K_B_PAT);
    for (int i = 0; i < 3; i++) applyStimulus(K_B_PAT);
    runFrame(K_B_PAT);

    for (int f = 0; f < 1000; f++) runFrame(K_RANDOM);

    // Drain the scoreboard without starting another frame.
    for (int i = 0; i < 8; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
      #1;
    end
    stopMon = 1'b1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected slots never emitted, required 0", expQ.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
